pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter for the FP datapath (mantissa alignment/normalisation).

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shift_stage.sv | 64 ++++++
 rtl/pipelined_barrel_shifter.sv | 107 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One combinational shift level (by 2^LEVEL) with sticky update; the last level applies saturation.
// Sticky ports exist only when SHIFTER_STICKY_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  input  logic             amt_bit_i,
  input  logic             sat_i,
`ifdef SHIFTER_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  localparam int SH   = 1 << LEVEL;
  localparam bit LAST = (LEVEL == AMT_W - 1);

  logic [WIDTH-1:0] shifted;
  logic             force_sat;
  logic             right_op;

  assign force_sat = LAST && sat_i;
  assign right_op  = (op_i == SHIFT_SRL) || (op_i == SHIFT_SRA);

  always_comb begin
    shifted = data_i;
    if (amt_bit_i) begin
      case (op_i)
        SHIFT_SLL: shifted = data_i << SH;
        SHIFT_SRL: shifted = data_i >> SH;
        SHIFT_SRA: shifted = WIDTH'($signed(data_i) >>> SH);
        default:   shifted = {data_i[SH-1:0], data_i[WIDTH-1:SH]};
      endcase
    end
  end

  // Saturation only matters for the zero/sign-fill ops; rotate is naturally modular.
  always_comb begin
    data_o = shifted;
    if (force_sat) begin
      case (op_i)
        SHIFT_SLL, SHIFT_SRL: data_o = '0;
        SHIFT_SRA:            data_o = {WIDTH{data_i[WIDTH-1]}};
        default:              data_o = shifted;
      endcase
    end
  end

`ifdef SHIFTER_STICKY_EN
  // Under saturation every surviving bit is discarded too, so fold them in.
  always_comb begin
    sticky_o = sticky_i;
    if (right_op && amt_bit_i) sticky_o = sticky_o | (|data_i[SH-1:0]);
    if (right_op && force_sat) sticky_o = sticky_o | (|shifted);
  end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered level per amount bit, global stall on backpressure.
// Define SHIFTER_STICKY_EN to build the sticky (discarded-bit OR) logic.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    shift_op_e        op;
    logic [AMT_W-1:0] amt;
    logic             sat;
`ifdef SHIFTER_STICKY_EN
    logic             sticky;
`endif
  } stage_t;

  // Handshake: a beat moves on in_valid && in_ready, a result leaves on out_valid && out_ready;
  // the whole pipe advances together (bubbles kept) whenever the output slot is free or draining.
  logic   adv;
  stage_t in_pl;
  stage_t stage_in  [AMT_W];
  stage_t stage_d   [AMT_W];
  stage_t stage_q   [AMT_W];
  logic   valid_q   [AMT_W];
  logic [WIDTH-1:0] lvl_data [AMT_W];
`ifdef SHIFTER_STICKY_EN
  logic             lvl_sticky [AMT_W];
`endif

  assign adv      = !valid_q[AMT_W-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    in_pl      = '0;
    in_pl.data = in_data;
    in_pl.op   = shift_op_e'(in_op);
    in_pl.amt  = in_amt;
    in_pl.sat  = {1'b0, in_amt} >= (AMT_W+1)'(WIDTH);
  end

  always_comb begin
    stage_in[0] = in_pl;
    for (int k = 1; k < AMT_W; k++) stage_in[k] = stage_q[k-1];
    for (int k = 0; k < AMT_W; k++) begin
      stage_d[k]      = stage_in[k];
      stage_d[k].data = lvl_data[k];
`ifdef SHIFTER_STICKY_EN
      stage_d[k].sticky = lvl_sticky[k];
`endif
    end
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_lvl
    shift_stage #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W),
      .LEVEL (k)
    ) u_stage (
      .data_i    (stage_in[k].data),
      .op_i      (stage_in[k].op),
      .amt_bit_i (stage_in[k].amt[k]),
      .sat_i     (stage_in[k].sat),
`ifdef SHIFTER_STICKY_EN
      .sticky_i  (stage_in[k].sticky),
      .sticky_o  (lvl_sticky[k]),
`endif
      .data_o    (lvl_data[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < AMT_W; k++) begin
        valid_q[k] <= 1'b0;
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < AMT_W; k++) valid_q[k] <= valid_q[k-1];
      for (int k = 0; k < AMT_W; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_valid = valid_q[AMT_W-1];
  assign out_data  = stage_q[AMT_W-1].data;
`ifdef SHIFTER_STICKY_EN
  assign out_sticky = stage_q[AMT_W-1].sticky;
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=11); sticky expectations follow SHIFTER_STICKY_EN.
module tb_pipelined_barrel_shifter;

  localparam int W = 11;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [A-1:0] in_amt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sticky;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] ror_exp [8] = '{11'h001, 11'h400, 11'h200, 11'h100,
                                11'h080, 11'h040, 11'h020, 11'h010};
  logic rand_done;

  pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got sticky=%b data=%h, expected sticky=%b data=%h",
                  name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic sticky_eff(input logic s);
`ifdef SHIFTER_STICKY_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                       input logic [A-1:0] amt);
    logic [W-1:0]   r;
    logic [W-1:0]   mask;
    logic [2*W-1:0] t;
    logic           s;
    int             n;
    n    = int'(amt);
    r    = '0;
    s    = 1'b0;
    mask = (n >= W) ? {W{1'b1}} : W'((1 << n) - 1);
    case (op)
      2'd0: r = (n >= W) ? '0 : (d << n);
      2'd1: begin r = (n >= W) ? '0 : (d >> n); s = |(d & mask); end
      2'd2: begin r = (n >= W) ? {W{d[W-1]}} : W'($signed(d) >>> n); s = |(d & mask); end
      default: begin t = {d, d} >> (n % W); r = t[W-1:0]; end
    endcase
    return {sticky_eff(s), r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [A-1:0] amt,
                      input logic [W:0] exp);
    int   waitc;
    logic acc;
    waitc    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    while (!acc && waitc < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waitc++;
    end
    if (acc) exp_q.push_back(exp);
    else check_int("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic send_dir(input logic [1:0] op, input logic [W-1:0] d, input logic [A-1:0] amt,
                          input logic [W-1:0] ed, input logic es);
    send(op, d, amt, {sticky_eff(es), ed});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    #1;
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic       held;
    logic [W:0] held_v;
    held   = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (out_valid && held) check("stall_hold", {out_sticky, out_data}, held_v);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check_int("unexpected_output", 1, 0);
          else check($sformatf("result[%0d]", n_out), {out_sticky, out_data}, exp_q.pop_front());
          n_out++;
        end
        held   = out_valid && !out_ready;
        held_v = {out_sticky, out_data};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = 2'd0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_int("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", {out_sticky, out_data}, '0);
    check_int("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // latency of a lone beat, counting the accepting edge as the first
    send_dir(2'd0, 11'h0A5, 4'd3, 11'h528, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int("latency", lat, A);
    drain();

    // directed vectors, back to back
    send_dir(2'd2, 11'h605, 4'd2,  11'h781, 1'b1);
    send_dir(2'd1, 11'h605, 4'd2,  11'h181, 1'b1);
    send_dir(2'd3, 11'h001, 4'd1,  11'h400, 1'b0);
    send_dir(2'd1, 11'h7FF, 4'd13, 11'h000, 1'b1);
    send_dir(2'd2, 11'h400, 4'd15, 11'h7FF, 1'b1);
    send_dir(2'd2, 11'h5A5, 4'd0,  11'h5A5, 1'b0);
    send_dir(2'd3, 11'h5A5, 4'd0,  11'h5A5, 1'b0);
    send_dir(2'd0, 11'h001, 4'd10, 11'h400, 1'b0);
    send_dir(2'd1, 11'h400, 4'd10, 11'h001, 1'b0);
    send_dir(2'd1, 11'h001, 4'd1,  11'h000, 1'b1);
    send_dir(2'd3, 11'h003, 4'd12, 11'h401, 1'b0);
    send_dir(2'd3, 11'h001, 4'd15, 11'h080, 1'b0);
    send_dir(2'd0, 11'h7FF, 4'd11, 11'h000, 1'b0);
    send_dir(2'd2, 11'h7F0, 4'd4,  11'h7FF, 1'b0);
    send_dir(2'd2, 11'h3F0, 4'd12, 11'h000, 1'b1);
    drain();

    // burst of 8 with out_ready dropping mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_dir(2'd3, 11'h001, 4'(i), ror_exp[i], 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset with beats in flight
    out_ready = 1'b0;
    send_dir(2'd1, 11'h7FF, 4'd1, 11'h3FF, 1'b1);
    send_dir(2'd1, 11'h7FF, 4'd2, 11'h1FF, 1'b1);
    send_dir(2'd1, 11'h7FF, 4'd3, 11'h0FF, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_int("pre_reset_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_int("async_reset_valid", int'(out_valid), 0);
    check("async_reset_data", {out_sticky, out_data}, '0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_int("post_reset_idle", int'(out_valid), 0);

    // random beats against the reference model with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [1:0]   op;
          logic [W-1:0] d;
          logic [A-1:0] amt;
          op  = 2'($urandom_range(0, 3));
          d   = W'($urandom_range(0, (1 << W) - 1));
          amt = A'($urandom_range(0, 15));
          send(op, d, amt, model(op, d, amt));
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
